tcs3200_capture: RTL and testbench

Colour-sensor front end feeding the `data_r`/`data_g`/`data_b` inputs of the LED draw path. It drives a TCS3200-class light-to-frequency sensor and cycles its filter select through red, green and blue. For each filter it counts the sensor's output edges over a fixed gate window, then scales each count to 8 bits. When a full RGB frame is complete, it publishes all three bytes together with a one-cycle valid strobe.

---
 rtl/tcs_pkg.sv | 25 ++
 rtl/tcs_edge_counter.sv | 40 ++++
 rtl/tcs3200_capture.sv | 137 +++++++++++++
 tb/tb_tcs3200_capture.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tcs_pkg.sv
// Shared types and constants for the TCS3200 colour capture block.
package tcs_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      GATE   = 2'd2,
      STORE  = 2'd3
   } state_e;

   localparam logic [1:0] FILT_R = 2'b00;
   localparam logic [1:0] FILT_G = 2'b11;
   localparam logic [1:0] FILT_B = 2'b01;

   localparam int CNT_W = 16;

   // Shift the raw count down, then clamp anything that still overflows a byte.
   function automatic logic [7:0] scale_sat(input logic [CNT_W-1:0] raw,
                                            input int unsigned     sh);
      logic [CNT_W-1:0] shifted;
      shifted = raw >> sh;
      return (|shifted[CNT_W-1:8]) ? 8'hFF : shifted[7:0];
   endfunction

endpackage

// File: rtl/tcs_edge_counter.sv
// Synchronises the sensor square wave, detects rising edges and counts them
// with saturation while cnt_en is high.
module tcs_edge_counter
   import tcs_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             sensor,
   input  logic             clr,
   input  logic             cnt_en,
   output logic [CNT_W-1:0] count
);

   logic sync_a;
   logic sync_b;
   logic prev;
   logic pulse;

   // Pin-to-pulse latency is three cycles: two synchroniser flops plus the
   // registered edge detect.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
         prev   <= 1'b0;
         pulse  <= 1'b0;
         count  <= '0;
      end else begin
         sync_a <= sensor;
         sync_b <= sync_a;
         prev   <= sync_b;
         pulse  <= sync_b & ~prev;
         if (clr)
            count <= '0;
         else if (cnt_en && pulse && (count != {CNT_W{1'b1}}))
            count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/tcs3200_capture.sv
// TCS3200 front end: steps the filter through R, G, B, counts sensor edges
// over a fixed gate per filter and publishes a scaled RGB frame.
module tcs3200_capture
   import tcs_pkg::*;
#(
   parameter int unsigned GATE_CYCLES   = 500_000,
   parameter int unsigned SETTLE_CYCLES = 5_000,
   parameter int unsigned SHIFT         = 4,
   parameter logic [1:0]  FREQ_SCALE    = 2'b10
)(
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       en,
   input  logic       sensor_out,
   output logic       s0,
   output logic       s1,
   output logic       s2,
   output logic       s3,
   output logic       oe_n,
   output logic [7:0] data_r,
   output logic [7:0] data_g,
   output logic [7:0] data_b,
   output logic       data_valid,
   output state_e     state
);

   // data_valid is a one-cycle strobe with no ready: data_r/g/b change only in
   // the cycle it is high and hold until the next strobe.

   logic [1:0]       ch;
   logic [1:0]       filt;
   logic [31:0]      timer;
   logic [7:0]       hold_r;
   logic [7:0]       hold_g;
   logic [CNT_W-1:0] count;
   logic [7:0]       scaled;
   logic             clr;
   logic             cnt_en;

   assign s0 = FREQ_SCALE[1];
   assign s1 = FREQ_SCALE[0];
   assign s2 = filt[1];
   assign s3 = filt[0];

   // Counter is held at zero outside the gate, so GATE always starts from 0.
   assign clr    = (state == IDLE) || (state == SETTLE);
   assign cnt_en = (state == GATE);
   assign scaled = scale_sat(count, SHIFT);

   tcs_edge_counter u_counter (
      .clk    (sys_clk),
      .rst    (sys_rst),
      .sensor (sensor_out),
      .clr    (clr),
      .cnt_en (cnt_en),
      .count  (count)
   );

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state      <= IDLE;
         ch         <= 2'd0;
         filt       <= FILT_R;
         timer      <= '0;
         hold_r     <= '0;
         hold_g     <= '0;
         data_r     <= '0;
         data_g     <= '0;
         data_b     <= '0;
         data_valid <= 1'b0;
         oe_n       <= 1'b1;
      end else begin
         oe_n       <= ~en;
         data_valid <= 1'b0;
         if (!en) begin
            // Abandon any partial frame; published bytes stay untouched.
            state  <= IDLE;
            ch     <= 2'd0;
            filt   <= FILT_R;
            timer  <= '0;
            hold_r <= '0;
            hold_g <= '0;
         end else begin
            case (state)
               IDLE: begin
                  state <= SETTLE;
                  ch    <= 2'd0;
                  filt  <= FILT_R;
                  timer <= '0;
               end
               SETTLE: begin
                  if (timer == SETTLE_CYCLES - 1) begin
                     state <= GATE;
                     timer <= '0;
                  end else begin
                     timer <= timer + 32'd1;
                  end
               end
               GATE: begin
                  if (timer == GATE_CYCLES - 1) begin
                     state <= STORE;
                     timer <= '0;
                  end else begin
                     timer <= timer + 32'd1;
                  end
               end
               STORE: begin
                  state <= SETTLE;
                  case (ch)
                     2'd0: begin
                        hold_r <= scaled;
                        ch     <= 2'd1;
                        filt   <= FILT_G;
                     end
                     2'd1: begin
                        hold_g <= scaled;
                        ch     <= 2'd2;
                        filt   <= FILT_B;
                     end
                     default: begin
                        // Blue goes straight to the output alongside the held R/G.
                        data_r     <= hold_r;
                        data_g     <= hold_g;
                        data_b     <= scaled;
                        data_valid <= 1'b1;
                        ch         <= 2'd0;
                        filt       <= FILT_R;
                     end
                  endcase
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tcs3200_capture.sv
// Self-checking bench: two instances (SHIFT=2 and SHIFT=0) share stimulus,
// each with its own expected-frame queue.
module tb_tcs3200_capture;
   import tcs_pkg::*;

   localparam int G_CYC     = 1000;
   localparam int S_CYC     = 10;
   localparam int FRAME_LAT = 1 + 3 * (S_CYC + G_CYC + 1);

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic       en;
   logic       sensor_out;

   logic       s0, s1, s2, s3, oe_n, data_valid;
   logic [7:0] data_r, data_g, data_b;
   state_e     state;

   logic       raw_s0, raw_s1, raw_s2, raw_s3, raw_oe_n, raw_valid;
   logic [7:0] raw_r, raw_g, raw_b;
   state_e     raw_state;

   int checks = 0;
   int errors = 0;

   logic [23:0] exp_q[$];
   logic [23:0] raw_q[$];
   logic [23:0] exp_mon;
   logic [23:0] raw_mon;

   int mode     = 0;
   int fixed_p  = 4;
   int took;

   always #5 sys_clk = ~sys_clk;

   tcs3200_capture #(
      .GATE_CYCLES   (G_CYC),
      .SETTLE_CYCLES (S_CYC),
      .SHIFT         (2),
      .FREQ_SCALE    (2'b10)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .en         (en),
      .sensor_out (sensor_out),
      .s0         (s0),
      .s1         (s1),
      .s2         (s2),
      .s3         (s3),
      .oe_n       (oe_n),
      .data_r     (data_r),
      .data_g     (data_g),
      .data_b     (data_b),
      .data_valid (data_valid),
      .state      (state)
   );

   tcs3200_capture #(
      .GATE_CYCLES   (G_CYC),
      .SETTLE_CYCLES (S_CYC),
      .SHIFT         (0),
      .FREQ_SCALE    (2'b10)
   ) dut_raw (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .en         (en),
      .sensor_out (sensor_out),
      .s0         (raw_s0),
      .s1         (raw_s1),
      .s2         (raw_s2),
      .s3         (raw_s3),
      .oe_n       (raw_oe_n),
      .data_r     (raw_r),
      .data_g     (raw_g),
      .data_b     (raw_b),
      .data_valid (raw_valid),
      .state      (raw_state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // Sensor model: mode 0 = silent, 1 = period chosen by filter code, 2 = fixed.
   // The phase restarts whenever the period changes so every gate sees a clean wave.
   initial begin : sensor_gen
      int p;
      int last_p;
      int ph;
      sensor_out = 1'b0;
      last_p     = 0;
      ph         = 0;
      forever begin
         @(negedge sys_clk);
         if (mode == 0)
            p = 0;
         else if (mode == 2)
            p = fixed_p;
         else
            case ({s2, s3})
               2'b11:   p = 20;
               2'b01:   p = 50;
               default: p = 10;
            endcase
         if (p != last_p) ph = 0;
         last_p = p;
         if (p == 0) begin
            sensor_out = 1'b0;
         end else begin
            sensor_out = (ph < p / 2);
            ph = (ph + 1 == p) ? 0 : ph + 1;
         end
      end
   end

   // Scoreboard: every strobe must match the oldest expected frame.
   always @(negedge sys_clk) begin
      if (data_valid) begin
         if (exp_q.size() == 0) begin
            check("unexp_valid", 32'(data_valid), 32'd0);
         end else begin
            exp_mon = exp_q.pop_front();
            check("frame", 32'({data_r, data_g, data_b}), 32'(exp_mon));
         end
      end
      if (raw_valid) begin
         if (raw_q.size() == 0) begin
            check("raw_unexp_valid", 32'(raw_valid), 32'd0);
         end else begin
            raw_mon = raw_q.pop_front();
            check("raw_frame", 32'({raw_r, raw_g, raw_b}), 32'(raw_mon));
         end
      end
   end

   task automatic wait_valid(input int budget, output int cycles);
      cycles = 0;
      do begin
         @(posedge sys_clk);
         #1;
         cycles++;
      end while (!data_valid && cycles < budget);
      if (!data_valid) check("valid_timeout", 32'(data_valid), 32'd1);
   endtask

   task automatic wait_state(input state_e st, input logic [1:0] code, input int budget);
      int n;
      n = 0;
      do begin
         @(posedge sys_clk);
         #1;
         n++;
      end while (!(state == st && {s2, s3} == code) && n < budget);
      if (!(state == st && {s2, s3} == code))
         check("state_timeout", 32'({state, s2, s3}), 32'({st, code}));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_data"},  32'({data_r, data_g, data_b}), 32'd0);
      check({tag, "_valid"}, 32'(data_valid), 32'd0);
      check({tag, "_oe_n"},  32'(oe_n), 32'd1);
      check({tag, "_filt"},  32'({s2, s3}), 32'd0);
      check({tag, "_freq"},  32'({s0, s1}), 32'(2'b10));
      check({tag, "_state"}, 32'(state), 32'(IDLE));
      check({tag, "_raw"},   32'({raw_r, raw_g, raw_b}), 32'd0);
   endtask

   initial begin
      sys_rst = 1'b1;
      en      = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1 sys_rst = 1'b0;
      repeat (20) @(posedge sys_clk);
      #1;
      check_reset_outputs("idle");

      // Frame 1: per-filter periods 10/20/50 -> counts 100/50/20.
      mode = 1;
      exp_q.push_back({8'd25, 8'd12, 8'd5});
      raw_q.push_back({8'd100, 8'd50, 8'd20});
      en = 1'b1;
      wait_valid(FRAME_LAT + 50, took);
      check("first_latency", 32'(took), 32'(FRAME_LAT));
      check("oe_n_run", 32'(oe_n), 32'd0);
      check("filt_after_frame", 32'({s2, s3}), 32'(FILT_R));

      // Frame 2: period 4 everywhere -> count 250.
      mode    = 2;
      fixed_p = 4;
      exp_q.push_back({8'd62, 8'd62, 8'd62});
      raw_q.push_back({8'd250, 8'd250, 8'd250});
      wait_valid(FRAME_LAT + 50, took);
      check("frame_period", 32'(took), 32'(FRAME_LAT - 1));

      // Frame 3: period 2 -> count 500, saturates only without the shift.
      fixed_p = 2;
      exp_q.push_back({8'd125, 8'd125, 8'd125});
      raw_q.push_back({8'd255, 8'd255, 8'd255});
      wait_valid(FRAME_LAT + 50, took);

      // Drop en in the middle of the green gate.
      mode = 1;
      wait_state(GATE, FILT_G, 2 * (S_CYC + G_CYC + 1) + 20);
      repeat (100) @(posedge sys_clk);
      #1 en = 1'b0;
      @(posedge sys_clk);
      #1;
      check("drop_state", 32'(state), 32'(IDLE));
      check("drop_hold", 32'({data_r, data_g, data_b}), 32'({8'd125, 8'd125, 8'd125}));
      check("drop_hold_raw", 32'({raw_r, raw_g, raw_b}), 32'({8'd255, 8'd255, 8'd255}));
      repeat (30) @(posedge sys_clk);
      #1;
      check("drop_oe_n", 32'(oe_n), 32'd1);
      check("drop_filt", 32'({s2, s3}), 32'(FILT_R));

      // Re-enable: a full frame from red with the same latency as the first.
      exp_q.push_back({8'd25, 8'd12, 8'd5});
      raw_q.push_back({8'd100, 8'd50, 8'd20});
      en = 1'b1;
      @(posedge sys_clk);
      #1;
      check("restart_state", 32'(state), 32'(SETTLE));
      check("restart_filt", 32'({s2, s3}), 32'(FILT_R));
      wait_valid(FRAME_LAT + 50, took);
      check("restart_latency", 32'(took + 1), 32'(FRAME_LAT));

      // Reset during the blue gate: nothing published afterwards.
      wait_state(GATE, FILT_B, 3 * (S_CYC + G_CYC + 1) + 20);
      repeat (200) @(posedge sys_clk);
      #1;
      sys_rst = 1'b1;
      en      = 1'b0;
      @(posedge sys_clk);
      #1;
      check_reset_outputs("rst_mid");
      sys_rst = 1'b0;
      repeat (4000) @(posedge sys_clk);
      #1;
      check_reset_outputs("rst_after");

      check("exp_left", 32'(exp_q.size()), 32'd0);
      check("raw_left", 32'(raw_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
